// File: rtl/moore_counter_n.sv
// Parametrised Moore event counter: up/down, level or rising-edge events,
// synchronous clear and clamped load, registered wrap pulse and terminal-count decode.
module moore_counter_n #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int EDGE_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x_in,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic             wrap,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             x_prev;
    logic             ev;
    logic [WIDTH-1:0] state_nxt;
    logic             wrap_nxt;

    // load_val < MODULUS is equivalent to load_val <= MAX, which stays in WIDTH bits
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX) ? MAX : v;
    endfunction

    assign ev = (EDGE_MODE != 0) ? (x_in & ~x_prev) : x_in;

    always_comb begin
        state_nxt = state;
        wrap_nxt  = 1'b0;
        if (clr) begin
            state_nxt = '0;
        end else if (load) begin
            state_nxt = clamp_load(load_val);
        end else if (ev) begin
            // wrap is decided against the modulus bounds, not by binary overflow
            if (dir) begin
                if (state == MAX) begin
                    state_nxt = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    state_nxt = state + ONE;
                end
            end else begin
                if (state == '0) begin
                    state_nxt = MAX;
                    wrap_nxt  = 1'b1;
                end else begin
                    state_nxt = state - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= '0;
            wrap   <= 1'b0;
            x_prev <= 1'b0;
        end else begin
            state  <= state_nxt;
            wrap   <= wrap_nxt;
            x_prev <= x_in;
        end
    end

    assign tc = (state == MAX);

endmodule

// File: tb/tb_moore_counter_n.sv
// Directed bench for moore_counter_n: several parameterisations share one stimulus bus,
// and each scenario task checks the instance it targets against hand-computed values.
module tb_moore_counter_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       x_in = 1'b0;
    logic       dir = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [1:0] st_l4, st_l2;
    logic [3:0] st_l10, st_e10, st_l16;
    logic       wr_l4, wr_l2, wr_l10, wr_e10, wr_l16;
    logic       tc_l4, tc_l2, tc_l10, tc_e10, tc_l16;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    moore_counter_n #(.WIDTH(2), .MODULUS(4), .EDGE_MODE(0)) u_l4 (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val[1:0]), .state(st_l4), .wrap(wr_l4), .tc(tc_l4));
    moore_counter_n #(.WIDTH(2), .MODULUS(2), .EDGE_MODE(0)) u_l2 (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val[1:0]), .state(st_l2), .wrap(wr_l2), .tc(tc_l2));
    moore_counter_n #(.WIDTH(4), .MODULUS(10), .EDGE_MODE(0)) u_l10 (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .state(st_l10), .wrap(wr_l10), .tc(tc_l10));
    moore_counter_n #(.WIDTH(4), .MODULUS(10), .EDGE_MODE(1)) u_e10 (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .state(st_e10), .wrap(wr_e10), .tc(tc_e10));
    moore_counter_n #(.WIDTH(4), .MODULUS(16), .EDGE_MODE(0)) u_l16 (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .state(st_l16), .wrap(wr_l16), .tc(tc_l16));

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        x_in = 1'b0; dir = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({st_l4, wr_l4, tc_l4} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_l4 got st/wr/tc=%b required 0000", {st_l4, wr_l4, tc_l4});
        end
        vectors++;
        if ({st_l10, wr_l10, tc_l10} !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_l10 got st/wr/tc=%b required 000000", {st_l10, wr_l10, tc_l10});
        end
        vectors++;
        if ({st_e10, wr_e10, tc_e10, st_l16, wr_l16, tc_l16, st_l2, wr_l2, tc_l2} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_others got %b required all zero",
                     {st_e10, wr_e10, tc_e10, st_l16, wr_l16, tc_l16, st_l2, wr_l2, tc_l2});
        end
    endtask

    // M=4 level count and M=2 back-to-back wraps on the same held-high input
    task automatic test_level_count();
        logic [1:0] exp_st4 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic       exp_wr4 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_tc4 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0] exp_st2 [5] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
        logic       exp_wr2 [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        x_in = 1'b1; dir = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({st_l4, wr_l4, tc_l4} !== {exp_st4[i], exp_wr4[i], exp_tc4[i]}) begin
                miscompares++;
                $display("FAIL level_m4[%0d] got st=%0d wr=%b tc=%b required st=%0d wr=%b tc=%b",
                         i, st_l4, wr_l4, tc_l4, exp_st4[i], exp_wr4[i], exp_tc4[i]);
            end
            vectors++;
            if ({st_l2, wr_l2, tc_l2} !== {exp_st2[i], exp_wr2[i], exp_st2[i][0]}) begin
                miscompares++;
                $display("FAIL b2b_wrap_m2[%0d] got st=%0d wr=%b tc=%b required st=%0d wr=%b tc=%b",
                         i, st_l2, wr_l2, tc_l2, exp_st2[i], exp_wr2[i], exp_st2[i][0]);
            end
        end
        x_in = 1'b0;
    endtask

    task automatic test_down_count();
        logic [3:0] exp_st [3] = '{4'd9, 4'd8, 4'd7};
        logic       exp_wt [3] = '{1'b1, 1'b0, 1'b0};
        do_reset();
        x_in = 1'b1; dir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({st_l10, wr_l10, tc_l10} !== {exp_st[i], exp_wt[i], exp_wt[i]}) begin
                miscompares++;
                $display("FAIL down_m10[%0d] got st=%0d wr=%b tc=%b required st=%0d wr=%b tc=%b",
                         i, st_l10, wr_l10, tc_l10, exp_st[i], exp_wt[i], exp_wt[i]);
            end
        end
        x_in = 1'b0;
    endtask

    task automatic test_edge_mode();
        logic       pat    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_st [8] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3};
        do_reset();
        dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x_in = pat[i];
            @(posedge clk); #1;
            vectors++;
            if ({st_e10, wr_e10} !== {exp_st[i], 1'b0}) begin
                miscompares++;
                $display("FAIL edge[%0d] got st=%0d wr=%b required st=%0d wr=0",
                         i, st_e10, wr_e10, exp_st[i]);
            end
        end
        x_in = 1'b0;
    endtask

    task automatic test_load_priority();
        // {load, clr, x_in, dir, load_val, expected state, expected wrap}
        logic [13:0] vec [8] = '{
            {1'b1, 1'b0, 1'b0, 1'b1, 4'd12, 4'd9, 1'b0},
            {1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  4'd0, 1'b0},
            {1'b1, 1'b0, 1'b1, 1'b1, 4'd5,  4'd5, 1'b0},
            {1'b1, 1'b0, 1'b0, 1'b1, 4'd10, 4'd9, 1'b0},
            {1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0, 1'b1},
            {1'b1, 1'b0, 1'b1, 1'b0, 4'd9,  4'd9, 1'b0},
            {1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  4'd0, 1'b0},
            {1'b1, 1'b0, 1'b1, 1'b0, 4'd3,  4'd3, 1'b0}
        };
        do_reset();
        for (int i = 0; i < 8; i++) begin
            {load, clr, x_in, dir, load_val} = vec[i][13:5];
            @(posedge clk); #1;
            vectors++;
            if ({st_l10, wr_l10} !== vec[i][4:0]) begin
                miscompares++;
                $display("FAIL load_prio[%0d] got st=%0d wr=%b required st=%0d wr=%b",
                         i, st_l10, wr_l10, vec[i][4:1], vec[i][0]);
            end
        end
        load = 1'b0; clr = 1'b0; x_in = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        load = 1'b1; load_val = 4'd7;
        @(posedge clk); #1;
        load = 1'b0;
        vectors++;
        if (st_e10 !== 4'd7) begin
            miscompares++;
            $display("FAIL async_preload got st=%0d required 7", st_e10);
        end
        #2;
        rst_n = 1'b0;
        x_in = 1'b1;
        #1;
        vectors++;
        if ({st_e10, wr_e10, tc_e10} !== 6'b000000) begin
            miscompares++;
            $display("FAIL async_reset got st=%0d wr=%b tc=%b required 0 0 0", st_e10, wr_e10, tc_e10);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (st_e10 !== 4'd1) begin
                miscompares++;
                $display("FAIL async_release_edge[%0d] got st=%0d required 1", i, st_e10);
            end
        end
        x_in = 1'b0;
    endtask

    task automatic test_dir_boundary();
        do_reset();
        load = 1'b1; load_val = 4'd15;
        @(posedge clk); #1;
        load = 1'b0;
        vectors++;
        if ({st_l16, wr_l16, tc_l16} !== {4'd15, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL dir_load15 got st=%0d wr=%b tc=%b required 15 0 1", st_l16, wr_l16, tc_l16);
        end
        x_in = 1'b1; dir = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({st_l16, wr_l16, tc_l16} !== {4'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL dir_up_wrap got st=%0d wr=%b tc=%b required 0 1 0", st_l16, wr_l16, tc_l16);
        end
        dir = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({st_l16, wr_l16, tc_l16} !== {4'd15, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL dir_down_wrap got st=%0d wr=%b tc=%b required 15 1 1", st_l16, wr_l16, tc_l16);
        end
        x_in = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({st_l16, wr_l16, tc_l16} !== {4'd15, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL dir_hold got st=%0d wr=%b tc=%b required 15 0 1", st_l16, wr_l16, tc_l16);
        end
    endtask

    initial begin
        test_reset();
        test_level_count();
        test_down_count();
        test_edge_mode();
        test_load_priority();
        test_async_reset();
        test_dir_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
